// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared opcode constants, control-flow kinds and FSM states for pc_ctrl
//   Contents: OP_JAL / OP_JALR / OP_BRANCH opcodes, cf_kind_t, pc_state_t,
//             decode_cf() opcode-to-kind classifier.
package pc_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {CF_NONE, CF_JAL, CF_JALR, CF_BR} cf_kind_t;
  typedef enum logic {RUN, WAIT} pc_state_t;

  function automatic cf_kind_t decode_cf(input logic [6:0] op);
    cf_kind_t k;
    case (op)
      OP_JAL:    k = CF_JAL;
      OP_JALR:   k = CF_JALR;
      OP_BRANCH: k = CF_BR;
      default:   k = CF_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - combinational redirect target and misalign detection for a resolved control op
//   i_kind      : kind of the pending control op
//   i_ip        : address of the control op
//   i_up_amt    : signed byte offset (JAL / branch)
//   i_tgt_abs   : absolute target (JALR)
//   i_b_taken   : branch outcome (only meaningful for CF_BR)
//   o_next_ip   : IP to load on resolution (TRAP_VECTOR when misaligned)
//   o_misalign  : taken target has bits[1:0] != 0
module pc_target
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              INC         = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100)
) (
  input  cf_kind_t          i_kind,
  input  logic [XLEN-1:0]   i_ip,
  input  logic [XLEN-1:0]   i_up_amt,
  input  logic [XLEN-1:0]   i_tgt_abs,
  input  logic              i_b_taken,
  output logic [XLEN-1:0]   o_next_ip,
  output logic              o_misalign
);

  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_abs;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_tgt;
  logic            w_taken;

  always_comb begin
    // Additions wrap modulo 2^XLEN with no detection.
    w_rel   = i_ip + i_up_amt;
    w_abs   = {i_tgt_abs[XLEN-1:1], 1'b0};
    w_seq   = i_ip + XLEN'(INC);
    w_taken = 1'b1;
    w_tgt   = w_rel;
    case (i_kind)
      CF_JALR: w_tgt   = w_abs;
      CF_BR:   w_taken = i_b_taken;
      default: ;
    endcase
    // A not-taken branch falls through to IP+INC and can never trap.
    o_misalign = w_taken && (w_tgt[1:0] != 2'b00);
    if (!w_taken)
      o_next_ip = w_seq;
    else if (o_misalign)
      o_next_ip = TRAP_VECTOR;
    else
      o_next_ip = w_tgt;
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program-counter controller holding fetch on control ops until execute resolves them
//   CLK, RESET_N  : clock (rising edge), asynchronous active-low reset
//   OP            : opcode of the instruction at IP
//   stall_in      : hazard hold, freezes IP in RUN
//   resolve_valid : resolution strobe for the pending control op
//   b_taken, up_amt, tgt_abs : resolution payload, sampled with resolve_valid
//   IP, PC_def    : fetch address and its sequential successor (link value)
//   fetch_valid   : instruction at IP is issued this cycle
//   pending       : waiting on resolution
//   misalign      : one-cycle pulse coincident with IP=TRAP_VECTOR
//   wait_cnt      : WAIT cycles so far including the current one, saturating
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              INC          = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [6:0]        OP,
  input  logic              stall_in,
  input  logic              resolve_valid,
  input  logic              b_taken,
  input  logic [XLEN-1:0]   up_amt,
  input  logic [XLEN-1:0]   tgt_abs,
  output logic [XLEN-1:0]   IP,
  output logic [XLEN-1:0]   PC_def,
  output logic              fetch_valid,
  output logic              pending,
  output logic              misalign,
  output logic [7:0]        wait_cnt
);

  pc_state_t       r_state,    w_state_nxt;
  cf_kind_t        r_kind,     w_kind_nxt;
  logic [XLEN-1:0] r_ip,       w_ip_nxt;
  logic [7:0]      r_wait_cnt, w_cnt_nxt;
  logic            r_misalign, w_mis_nxt;
  logic            w_fetch_valid;
  cf_kind_t        w_op_kind;
  logic [XLEN-1:0] w_tgt_ip;
  logic            w_tgt_mis;

  assign w_op_kind = decode_cf(OP);

  pc_target #(
    .XLEN        (XLEN),
    .INC         (INC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target (
    .i_kind     (r_kind),
    .i_ip       (r_ip),
    .i_up_amt   (up_amt),
    .i_tgt_abs  (tgt_abs),
    .i_b_taken  (b_taken),
    .o_next_ip  (w_tgt_ip),
    .o_misalign (w_tgt_mis)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= RUN;
      r_kind     <= CF_NONE;
      r_ip       <= RESET_VECTOR;
      r_wait_cnt <= 8'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_ip       <= w_ip_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_misalign <= w_mis_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_kind_nxt    = r_kind;
    w_ip_nxt      = r_ip;
    w_cnt_nxt     = r_wait_cnt;
    w_mis_nxt     = 1'b0;
    w_fetch_valid = 1'b0;
    case (r_state)
      RUN: begin
        // resolve_valid is deliberately not looked at here.
        if (!stall_in) begin
          w_fetch_valid = 1'b1;
          if (w_op_kind != CF_NONE) begin
            w_kind_nxt  = w_op_kind;
            w_state_nxt = WAIT;
            // Counts the WAIT cycle being entered, so it reads 1 in the first WAIT cycle.
            w_cnt_nxt   = 8'd1;
          end else begin
            w_ip_nxt = r_ip + XLEN'(INC);
          end
        end
      end
      WAIT: begin
        if (resolve_valid) begin
          w_ip_nxt    = w_tgt_ip;
          w_mis_nxt   = w_tgt_mis;
          w_state_nxt = RUN;
          w_kind_nxt  = CF_NONE;
          w_cnt_nxt   = 8'd0;
        end else if (r_wait_cnt != 8'hFF) begin
          w_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign IP          = r_ip;
  assign PC_def      = r_ip + XLEN'(INC);
  assign fetch_valid = w_fetch_valid;
  assign pending     = (r_state == WAIT);
  assign misalign    = r_misalign;
  assign wait_cnt    = r_wait_cnt;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller for the single-issue fetch stage, and the successor to the fixed 32-bit PC with its one-cycle stall.
- Holds fetch at a control-flow op (JAL, JALR, BRANCH) until the execute stage signals resolution through a valid handshake; latency is variable.
- Supports relative targets (JAL/branch) and absolute targets (JALR).
- Adds an external hazard stall, misaligned-target trapping and configurable reset/trap vectors.
- Sits between the instruction-memory address port and decode/execute.

Parameters:
XLEN, 32, address/data width of IP, PC_def, up_amt, tgt_abs
RESET_VECTOR, 0, IP value while reset is asserted and after release
TRAP_VECTOR, 32'h100, IP loaded when a taken target is misaligned
INC, 4, sequential increment in bytes

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
OP  in  7  opcode of instruction at IP (from imem/decode)
stall_in  in  1  hazard hold from decode; freezes IP in RUN
resolve_valid  in  1  execute stage resolution strobe for the pending control op
b_taken  in  1  branch taken, sampled with resolve_valid (ignored for JAL/JALR: always taken)
up_amt  in  XLEN  signed byte offset for JAL/branch, sampled with resolve_valid
tgt_abs  in  XLEN  JALR absolute target, sampled with resolve_valid
IP  out  XLEN  current fetch address
PC_def  out  XLEN  IP + INC, combinational (link value)
fetch_valid  out  1  instruction at IP is issued this cycle
pending  out  1  high while waiting on resolution
misalign  out  1  one-cycle pulse when trap redirect is taken
wait_cnt  out  8  cycles spent in current WAIT, saturating at 255

Behaviour:
- Reset (RESET_N=0, asynchronous): IP=RESET_VECTOR, state=RUN, pending=0, misalign=0, wait_cnt=0, kind register cleared. Reset mid-WAIT abandons the pending op.
- Control op decode: OP==7'b1101111 (JAL), 7'b1100111 (JALR), 7'b1100011 (BRANCH); all other opcodes are sequential.
- State RUN:
  - stall_in=1: IP holds, OP ignored, fetch_valid=0.
  - Control op with stall_in=0: fetch_valid=1. Next edge latches the op kind, holds IP and enters WAIT.
  - Otherwise: fetch_valid=1 and IP <= IP+INC.
- State WAIT:
  - Outputs: pending=1, fetch_valid=0. wait_cnt increments each cycle, saturating.
  - stall_in is ignored; a redirect overrides it.
  - No resolve_valid: IP holds.
  - resolve_valid=1: compute next IP. JAL gives IP+up_amt. BRANCH gives IP+up_amt if b_taken, else IP+INC. JALR gives tgt_abs with bit0 cleared.
  - Transition: return to RUN with the computed IP and wait_cnt=0.
- resolve_valid in RUN is ignored (spurious). No state change.
- resolve_valid in the same cycle WAIT is entered is not possible; WAIT starts next edge. resolve_valid is accepted from the first WAIT cycle.
- Misalign: a taken/JAL/JALR target with bits[1:0]!=0 loads IP=TRAP_VECTOR and pulses misalign for one cycle. A not-taken branch never traps.
- Arithmetic: all additions are modulo 2^XLEN; wrap at the top of the address space is silent.
- Only one control op can be outstanding; no speculation past it.
- Latency: a resolution at cycle N gives the new IP visible at N+1. Minimum control-op penalty is 1 bubble.

Decomposition:
- Package pc_pkg: opcode constants OP_JAL, OP_JALR, OP_BRANCH; enum cf_kind_t {CF_NONE, CF_JAL, CF_JALR, CF_BR}; enum pc_state_t {RUN, WAIT}.
- Sub-module pc_target: combinational next-target calculator. Inputs: kind, IP, up_amt, tgt_abs, b_taken. Outputs: next IP and misalign flag.

Test Plan:
- Reset/sequential: RESET_N low for 3 cycles, then release with 4 ADD opcodes. IP sequence 0,4,8,12,16; fetch_valid=1 throughout; async reset mid-cycle forces IP=0 immediately.
- Branch taken after 3-cycle wait: BRANCH at IP=0x10, resolve_valid after 3 WAIT cycles with b_taken=1, up_amt=-8. pending high 3 cycles, wait_cnt reaches 3, IP=0x08 next cycle.
- Branch not taken with stall: BRANCH at 0x20 while stall_in=1 for 2 cycles. IP holds with no WAIT; then WAIT, resolve b_taken=0 gives IP=0x24.
- JALR: tgt_abs=0x1235 resolved in the first WAIT cycle gives IP=0x1234 and misalign=0. A JAL with up_amt=6 at 0x40 gives IP=TRAP_VECTOR and a one-cycle misalign pulse.
- Spurious/reset: resolve_valid in RUN leaves IP stepping by 4. Reset during WAIT returns to RUN at RESET_VECTOR with pending=0. Wrap: IP=0xFFFFFFFC with ADD gives 0.
